// File: rtl/note_compose_pkg.sv
// Shared types and constants for the note-number compose/split family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t               - 2-bit FSM state of the iterative composer
//   SEMITONES_PER_OCTAVE  - semitones added per octave step
//   MIDI_NOTE_MAX         - highest legal MIDI note number
package note_compose_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      ADJUST = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int SEMITONES_PER_OCTAVE = 12;
   localparam int MIDI_NOTE_MAX        = 127;

endpackage

// File: rtl/note_clamp.sv
// Saturates a 10-bit signed note sum into 0..MAX_NOTE and flags saturation.
// Latency: combinational, zero cycles.
// Backpressure: none; this block is pure logic.
//
// Ports:
//   sum     in   10  signed two's-complement note sum
//   note    out   8  saturated note number
//   clamped out   1  high when sum was below 0 or above MAX_NOTE
module note_clamp
   import note_compose_pkg::*;
#(
   parameter int MAX_NOTE = MIDI_NOTE_MAX
) (
   input  logic [9:0] sum,
   output logic [7:0] note,
   output logic       clamped
);

   localparam logic signed [9:0] MAX_S = 10'(MAX_NOTE);

   always_comb begin
      note    = sum[7:0];
      clamped = 1'b0;
      if ($signed(sum) < 10'sd0) begin
         note    = 8'd0;
         clamped = 1'b1;
      end else if ($signed(sum) > MAX_S) begin
         note    = MAX_S[7:0];
         clamped = 1'b1;
      end
   end

endmodule

// File: rtl/note_compose.sv
// Rebuilds a MIDI note from pitch class + octave, applies a signed transpose, clamps.
// Latency: done_out follows accept edge octave_in+3 (error path: edge 1).
// Backpressure: ready_out high only in IDLE; valid_in while busy is dropped, not queued.
//
// Ports:
//   clk_in       in   1  system clock
//   rst_n_in     in   1  asynchronous active-low reset
//   valid_in     in   1  request strobe, accepted when valid_in && ready_out
//   pitch_in     in   4  pitch class 0..11 (12..15 flagged as error)
//   octave_in    in   4  number of STEP additions
//   transpose_in in   8  signed semitone offset
//   ready_out    out  1  block is idle and can accept
//   note_out     out  8  composed note, held until the next done
//   done_out     out  1  one-cycle pulse when note/flags update
//   clamped_out  out  1  result saturated at 0 or MAX_NOTE
//   error_out    out  1  accepted request had an illegal pitch class
module note_compose
   import note_compose_pkg::*;
#(
   parameter int MAX_NOTE = MIDI_NOTE_MAX,
   parameter int STEP     = SEMITONES_PER_OCTAVE
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       valid_in,
   input  logic [3:0] pitch_in,
   input  logic [3:0] octave_in,
   input  logic [7:0] transpose_in,
   output logic       ready_out,
   output logic [7:0] note_out,
   output logic       done_out,
   output logic       clamped_out,
   output logic       error_out
);

   state_t     state;
   state_t     state_nxt;

   logic [9:0] acc;        // signed running note value
   logic [3:0] cnt;        // octave additions still to do
   logic [7:0] xpose;      // transpose captured at accept
   logic       err;        // accepted pitch class was illegal
   logic [7:0] res_note;   // clamped result captured in ADJUST
   logic       res_clamp;

   logic       accept;
   logic [9:0] sum;
   logic [7:0] clamp_note;
   logic       clamp_flag;

   assign accept = valid_in && ready_out;

   // Worst case 11 + 15*12 + 127 = 318 and 0 - 128 = -128 both fit in 10 bits signed.
   assign sum = acc + {{2{xpose[7]}}, xpose};

   note_clamp #(
      .MAX_NOTE (MAX_NOTE)
   ) u_clamp (
      .sum     (sum),
      .note    (clamp_note),
      .clamped (clamp_flag)
   );

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (pitch_in > 4'd11) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (cnt == 4'd0) begin
               state_nxt = ADJUST;
            end
         end
         ADJUST:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ready_out = (state == IDLE);
   end

   // Accumulator / operand datapath
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         acc       <= '0;
         cnt       <= '0;
         xpose     <= '0;
         err       <= 1'b0;
         res_note  <= '0;
         res_clamp <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc   <= {6'd0, pitch_in};
                  cnt   <= octave_in;
                  xpose <= transpose_in;
                  err   <= (pitch_in > 4'd11);
               end
            end
            ACCUM: begin
               if (cnt != 4'd0) begin
                  acc <= acc + 10'(STEP);
                  cnt <= cnt - 4'd1;
               end
            end
            ADJUST: begin
               res_note  <= clamp_note;
               res_clamp <= clamp_flag;
            end
            default: ;
         endcase
      end
   end

   // Visible results only change on leaving DONE, so they hold through IDLE.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         note_out    <= '0;
         clamped_out <= 1'b0;
         error_out   <= 1'b0;
         done_out    <= 1'b0;
      end else begin
         done_out <= (state == DONE);
         if (state == DONE) begin
            if (err) begin
               note_out    <= '0;
               clamped_out <= 1'b0;
               error_out   <= 1'b1;
            end else begin
               note_out    <= res_note;
               clamped_out <= res_clamp;
               error_out   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/note_compose.md
Name: note_compose

Overview:
- Inverse of the note-number → pitch-class/octave splitter: rebuilds a MIDI note number from a pitch class (0–11) and an octave count.
- Applies an optional signed semitone transpose, then clamps the result to the MIDI range.
- Sits between the pitch-detection/chord logic and the MIDI/synth output path.
- Uses iterative add-by-12 (no multiplier), with a ready/valid input handshake and a one-cycle done pulse.

Parameters:
- MAX_NOTE, 127: upper clamp bound for note_out.
- STEP, 12: semitones per octave added per accumulate cycle.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- valid_in  input  1  request strobe; accepted when valid_in && ready_out at a clk_in edge.
- pitch_in  input  4  pitch class; values 12–15 are illegal.
- octave_in  input  4  octave count 0–15; the number of STEP additions.
- transpose_in  input  8  signed two's-complement semitone offset.
- ready_out  output  1  high only in IDLE.
- note_out  output  8  composed note number, 0..MAX_NOTE.
- done_out  output  1  one-cycle pulse when note_out and flags update.
- clamped_out  output  1  result was clamped, either below 0 or above MAX_NOTE.
- error_out  output  1  pitch_in > 11 on the accepted request.

Behaviour:
- Clock/reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- Reset values: state IDLE; note_out 0; done_out 0; clamped_out 0; error_out 0; internal accumulator and counter 0. ready_out = 1 while in reset and immediately after release.
- Reset mid-operation clears everything asynchronously. The in-flight request is dropped and produces no done pulse.
- States: IDLE, ACCUM, ADJUST, DONE.
- IDLE:
  - ready_out = 1; done_out driven 0.
  - On accept, latch pitch, octave and transpose; acc (10-bit signed) <= pitch_in; cnt <= octave_in.
  - If pitch_in > 11: set err flag and go to DONE. Otherwise go to ACCUM.
  - valid_in without acceptance (not IDLE) is ignored; there is no queueing.
- ACCUM:
  - If cnt != 0: acc <= acc + STEP; cnt <= cnt − 1.
  - Else go to ADJUST.
- ADJUST:
  - sum = acc + sign-extended transpose, 10-bit signed. Range is −128..318, so there is no overflow.
  - sum < 0 → result 0, clamp flag 1.
  - sum > MAX_NOTE → result MAX_NOTE, clamp flag 1.
  - Else result = sum, clamp flag 0.
  - Go to DONE.
- DONE:
  - Register note_out, clamped_out and error_out. For the error path: note_out 0, clamped_out 0, error_out 1.
  - done_out <= 1 for exactly one cycle; go to IDLE.
- Latency, counting the accept edge as edge 0:
  - Normal path: done_out is high in the cycle following edge octave_in + 3.
  - Error path: done_out is high following edge 1.
- Throughput: next accept is possible at the edge after DONE. ready_out is deasserted from accept until return to IDLE.
- Holding: note_out, clamped_out and error_out hold their values until the next DONE. They are not cleared in IDLE.
- Boundaries:
  - octave_in = 0 → ACCUM lasts one cycle; done follows edge 3.
  - octave_in = 15 with pitch_in = 11 → 191, clamped to MAX_NOTE.
  - transpose_in = −128 on small notes clamps to 0.
  - Inputs changing after accept have no effect.

Decomposition:
- Shared package: state enum (IDLE, ACCUM, ADJUST, DONE, 2-bit); constants SEMITONES_PER_OCTAVE = 12 and MIDI_NOTE_MAX = 127, used by this block and the splitter.
- No sub-module needed. Optionally factor the clamp (10-bit signed → 8-bit saturate plus flag) into note_clamp, shared with other transpose paths.

Test Plan:
- pitch 0, octave 5, transpose 0 → note_out 60, clamped 0, error 0; done high after edge 8; ready_out low for edges 1–8.
- pitch 9, octave 5, transpose +3 → note_out 72, clamped 0; done after edge 8.
- pitch 11, octave 10, transpose 0 → sum 131 → note_out 127, clamped_out 1; done after edge 13.
- pitch 2, octave 0, transpose −5 (0xFB) → note_out 0, clamped_out 1; done after edge 3.
- pitch 12, octave 4 → error_out 1, note_out 0; done after edge 1; no ACCUM cycles.
- Back-to-back pair plus reset:
  - Start pitch 4, octave 6. Pulse valid again while busy → ignored.
  - Assert rst_n_in low during ACCUM → outputs 0 immediately, no done pulse, ready_out 1.
  - After release, pitch 4, octave 6 → note_out 76.
